// File: rtl/iob_cache_line_fill_buffer.sv
// Cache line fill buffer: assembles back-end read beats into a full line and
// hands the line plus the requested word to the consumer via valid/ready.
module iob_cache_line_fill_buffer #(
    parameter int DATA_W        = 32,
    parameter int BE_DATA_W     = 64,
    parameter int WORD_OFFSET_W = 3,
    localparam int LINE2BE_W    = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W),
    localparam int NBEATS       = 2 ** LINE2BE_W,
    localparam int BA_W         = (LINE2BE_W > 0) ? LINE2BE_W : 1,
    localparam int MW_W         = (WORD_OFFSET_W > 0) ? WORD_OFFSET_W : 1,
    localparam int LINE_W       = BE_DATA_W * NBEATS
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 miss_valid_i,
    input  logic [MW_W-1:0]      miss_word_i,
    input  logic                 replace_i,
    input  logic                 read_valid_i,
    input  logic [BA_W-1:0]      read_addr_i,
    input  logic [BE_DATA_W-1:0] read_rdata_i,
    output logic                 busy_o,
    output logic                 line_valid_o,
    input  logic                 line_ready_i,
    output logic [LINE_W-1:0]    line_data_o,
    output logic [DATA_W-1:0]    word_o,
    output logic                 err_o
);

    localparam int NWORDS = 2 ** WORD_OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } state_t;

    state_t              state, state_next;
    logic [NBEATS-1:0]   mask, beat_hit, mask_upd;
    logic                replace_seen;
    logic [MW_W-1:0]     miss_word;
    logic [LINE_W-1:0]   line;
    logic                err, err_next;
    logic [BA_W-1:0]     beat_idx;
    logic [DATA_W-1:0]   word;

    // A single-beat line has no beat address; everything lands in beat 0.
    generate
        if (LINE2BE_W > 0) begin : g_addr
            assign beat_idx = read_addr_i;
        end else begin : g_noaddr
            logic unused_addr;
            assign unused_addr = ^read_addr_i;
            assign beat_idx    = '0;
        end
    endgenerate

    always_comb begin
        beat_hit = '0;
        if (read_valid_i) begin
            for (int unsigned k = 0; k < NBEATS; k++) begin
                if (beat_idx == BA_W'(k)) beat_hit[k] = 1'b1;
            end
        end
    end

    // The beat sampled together with replace_i low still counts toward completeness.
    assign mask_upd = mask | beat_hit;

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (miss_valid_i) state_next = FILL;
            end
            FILL: begin
                if (replace_seen && !replace_i) begin
                    if (&mask_upd) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (line_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            err          <= 1'b0;
            mask         <= '0;
            replace_seen <= 1'b0;
            miss_word    <= '0;
            line         <= '0;
        end else begin
            state <= state_next;
            err   <= err_next;
            case (state)
                IDLE: begin
                    if (miss_valid_i) begin
                        miss_word    <= (WORD_OFFSET_W > 0) ? miss_word_i : '0;
                        mask         <= '0;
                        replace_seen <= 1'b0;
                    end
                end
                FILL: begin
                    mask <= mask_upd;
                    if (replace_i) replace_seen <= 1'b1;
                    for (int unsigned k = 0; k < NBEATS; k++) begin
                        if (beat_hit[k]) line[k*BE_DATA_W +: BE_DATA_W] <= read_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        word = '0;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (miss_word == MW_W'(w)) word = line[w*DATA_W +: DATA_W];
        end
    end

    assign busy_o       = (state != IDLE);
    assign line_valid_o = (state == COMMIT);
    assign line_data_o  = line;
    assign word_o       = word;
    assign err_o        = err;

endmodule

// File: tb/tb_iob_cache_line_fill_buffer.sv
// Bench for the line fill buffer: a line-level model checked every cycle on the
// 4-beat configuration, plus directed literal checks on both configurations.
module tb_iob_cache_line_fill_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-beat configuration (64-bit beats, 8 words per line)
    logic         reset = 1'b1, miss_valid = 1'b0, replace = 1'b0, read_valid = 1'b0, line_ready = 1'b0;
    logic [2:0]   miss_word = '0;
    logic [1:0]   read_addr = '0;
    logic [63:0]  read_rdata = '0;
    logic         busy, line_valid, err;
    logic [255:0] line_data;
    logic [31:0]  word;

    // single-beat configuration
    logic         s_reset = 1'b1, s_miss = 1'b0, s_replace = 1'b0, s_rv = 1'b0, s_ready = 1'b0;
    logic [0:0]   s_mw = '0, s_addr = '0;
    logic [31:0]  s_rdata = '0;
    logic         s_busy, s_lv, s_err;
    logic [31:0]  s_line, s_word;

    iob_cache_line_fill_buffer #(.DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3)) dut (
        .clk_i(clk), .reset_i(reset), .miss_valid_i(miss_valid), .miss_word_i(miss_word),
        .replace_i(replace), .read_valid_i(read_valid), .read_addr_i(read_addr),
        .read_rdata_i(read_rdata), .busy_o(busy), .line_valid_o(line_valid),
        .line_ready_i(line_ready), .line_data_o(line_data), .word_o(word), .err_o(err)
    );

    iob_cache_line_fill_buffer #(.DATA_W(32), .BE_DATA_W(32), .WORD_OFFSET_W(0)) dut_s (
        .clk_i(clk), .reset_i(s_reset), .miss_valid_i(s_miss), .miss_word_i(s_mw),
        .replace_i(s_replace), .read_valid_i(s_rv), .read_addr_i(s_addr),
        .read_rdata_i(s_rdata), .busy_o(s_busy), .line_valid_o(s_lv),
        .line_ready_i(s_ready), .line_data_o(s_line), .word_o(s_word), .err_o(s_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Line-level model: filling / presenting flags, arrived-beat set, beat storage.
    bit          m_fill, m_pres, m_seen, m_err, m_close;
    bit [3:0]    m_got;
    logic [63:0] m_beat [4];
    int          m_word;

    always @(posedge clk) begin
        if (reset) begin
            m_fill = 0; m_pres = 0; m_seen = 0; m_err = 0; m_got = '0; m_word = 0;
            for (int i = 0; i < 4; i++) m_beat[i] = '0;
        end else begin
            m_err = 0;
            if (m_pres) begin
                if (line_ready) m_pres = 0;
            end else if (m_fill) begin
                m_close = m_seen && !replace;
                if (read_valid) begin
                    m_beat[read_addr] = read_rdata;
                    m_got[read_addr]  = 1'b1;
                end
                if (replace) m_seen = 1;
                if (m_close) begin
                    m_fill = 0;
                    if (m_got == 4'hF) m_pres = 1;
                    else m_err = 1;
                end
            end else if (miss_valid) begin
                m_fill = 1; m_got = '0; m_seen = 0; m_word = miss_word;
            end
        end
    end

    logic [255:0] m_line;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) m_line[i*64 +: 64] = m_beat[i];
        check("busy", busy, m_fill | m_pres);
        check("line_valid", line_valid, m_pres);
        check("err", err, m_err);
        check("line_data", line_data, m_line);
        check("word", word, m_line[m_word*32 +: 32]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [1:0] a, input logic [63:0] d);
        read_valid = 1'b1; read_addr = a; read_rdata = d;
        tick();
        read_valid = 1'b0;
    endtask

    task automatic start_fill(input logic [2:0] mw);
        miss_valid = 1'b1; miss_word = mw;
        tick();
        miss_valid = 1'b0; replace = 1'b1;
    endtask

    logic [255:0] exp_l;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset
        tick(); tick();
        check("rst_line", line_data, 256'h0);
        check("rst_word", word, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", line_valid, 1'b0);
        reset = 1'b0;

        // full in-order fill, latency and requested word
        start_fill(3'd5);
        for (int k = 0; k < 4; k++) send_beat(2'(k), 64'h1111111100000000 + 64'(k));
        tick();
        check("lat_before", line_valid, 1'b0);
        replace = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) exp_l[k*64 +: 64] = 64'h1111111100000000 + 64'(k);
        check("lat_valid", line_valid, 1'b1);
        check("fill_line", line_data, exp_l);
        check("fill_word", word, 32'h11111111);
        check("fill_beat3", line_data[255:192], 64'h1111111100000003);
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        check("release_valid", line_valid, 1'b0);
        check("release_busy", busy, 1'b0);

        // retry overwrites beat 2; ready tied high gives a single-cycle valid
        start_fill(3'd4);
        send_beat(2'd0, 64'h20);
        send_beat(2'd1, 64'h21);
        send_beat(2'd2, 64'hAAAA);
        send_beat(2'd2, 64'hBBBB);
        send_beat(2'd3, 64'h23);
        replace = 1'b0; line_ready = 1'b1;
        tick();
        check("retry_valid", line_valid, 1'b1);
        check("retry_err", err, 1'b0);
        check("retry_beat2", line_data[191:128], 64'hBBBB);
        check("retry_word", word, 32'hBBBB);
        tick();
        line_ready = 1'b0;
        check("pulse_valid", line_valid, 1'b0);

        // incomplete line
        start_fill(3'd0);
        send_beat(2'd0, 64'h30);
        send_beat(2'd1, 64'h31);
        send_beat(2'd2, 64'h32);
        replace = 1'b0;
        tick();
        check("inc_err", err, 1'b1);
        check("inc_valid", line_valid, 1'b0);
        check("inc_busy", busy, 1'b0);
        tick();
        check("inc_err_once", err, 1'b0);
        check("inc_busy_next", busy, 1'b0);

        // stalled commit ignores new misses and stray beats
        start_fill(3'd1);
        for (int k = 0; k < 4; k++) send_beat(2'(k), 64'hC0C0C0C000000000 + 64'(k));
        for (int k = 0; k < 4; k++) exp_l[k*64 +: 64] = 64'hC0C0C0C000000000 + 64'(k);
        replace = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            miss_valid = 1'b1; miss_word = 3'(c);
            read_valid = 1'b1; read_addr = 2'(c); read_rdata = 64'hDEAD0000 + 64'(c);
            tick();
            check("stall_valid", line_valid, 1'b1);
            check("stall_line", line_data, exp_l);
            check("stall_word", word, 32'hC0C0C0C0);
        end
        read_valid = 1'b0; line_ready = 1'b1;
        tick();
        miss_valid = 1'b0; line_ready = 1'b0;
        check("stall_exit_valid", line_valid, 1'b0);
        check("stall_exit_busy", busy, 1'b0);
        tick();
        check("stall_no_capture", busy, 1'b0);

        // reset mid-fill clears everything including the arrived-beat set
        start_fill(3'd2);
        send_beat(2'd0, 64'h50);
        send_beat(2'd1, 64'h51);
        reset = 1'b1;
        tick();
        reset = 1'b0; replace = 1'b0;
        check("midrst_line", line_data, 256'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", line_valid, 1'b0);
        check("midrst_err", err, 1'b0);
        start_fill(3'd2);
        send_beat(2'd2, 64'h62);
        send_beat(2'd3, 64'h63);
        replace = 1'b0;
        tick();
        check("midrst_empty_mask", err, 1'b1);

        // randomized fills against the model
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                read_valid = 1'($urandom); read_addr = 2'($urandom);
                read_rdata = {$urandom, $urandom};
                tick();
            end
            read_valid = 1'b0;
            start_fill(3'($urandom));
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) != 0) begin
                    send_beat(2'(k), {$urandom, $urandom});
                    if ($urandom_range(0, 3) == 0) send_beat(2'(k), {$urandom, $urandom});
                end
            end
            if (n % 10 == 7) begin
                reset = 1'b1;
                tick();
                reset = 1'b0; replace = 1'b0;
                continue;
            end
            repeat ($urandom_range(0, 2)) tick();
            replace = 1'b0;
            read_valid = 1'($urandom); read_addr = 2'($urandom);
            read_rdata = {$urandom, $urandom}; line_ready = 1'($urandom);
            tick();
            read_valid = 1'b0;
            for (int c = 0; c < 40 && m_pres; c++) begin
                line_ready = (c > 20) || ($urandom_range(0, 2) == 0);
                miss_valid = 1'($urandom); miss_word = 3'($urandom);
                read_valid = 1'($urandom); read_rdata = {$urandom, $urandom};
                tick();
            end
            miss_valid = 1'b0; read_valid = 1'b0; line_ready = 1'b0;
            check("rand_commit_exit", line_valid, 1'b0);
        end

        // single-beat line
        tick();
        check("s_rst_line", s_line, 32'h0);
        check("s_rst_busy", s_busy, 1'b0);
        s_reset = 1'b0;
        s_miss = 1'b1;
        tick();
        s_miss = 1'b0; s_replace = 1'b1;
        s_rv = 1'b1; s_addr = 1'b1; s_rdata = 32'hDEADBEEF;
        tick();
        s_rv = 1'b0; s_replace = 1'b0;
        tick();
        check("s_valid", s_lv, 1'b1);
        check("s_err", s_err, 1'b0);
        check("s_line", s_line, 32'hDEADBEEF);
        check("s_word", s_word, 32'hDEADBEEF);
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        check("s_release", s_lv, 1'b0);
        check("s_busy", s_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_cache_line_fill_buffer.md
Name: iob_cache_line_fill_buffer

Overview:
- Downstream consumer of the AXI read-channel beat stream (read_valid/read_addr/read_rdata) during a cache line replacement.
- Assembles the back-end beats into one full cache line and tracks which beats have arrived.
- Once the read channel releases replacement, presents the complete line plus the originally requested word to the data/tag memories and the front-end through a valid/ready handshake.
- Burst retries after a slave error overwrite earlier beats, so only the final data is committed.

Parameters:
- DATA_W, 32, front-end word width (bits).
- BE_DATA_W, 64, back-end beat width (bits); multiple of DATA_W.
- WORD_OFFSET_W, 3, log2(words per line).
- LINE2BE_W, WORD_OFFSET_W-$clog2(BE_DATA_W/DATA_W), derived; log2(beats per line); may be 0.
- NBEATS, 2**LINE2BE_W, derived.
- BA_W, (LINE2BE_W>0 ? LINE2BE_W : 1), derived beat-address port width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- miss_valid_i  in  1  pulse; starts a fill; sampled only in IDLE
- miss_word_i  in  WORD_OFFSET_W  requested word offset inside the line
- replace_i  in  1  read channel busy with the replacement (high from accept until fill done)
- read_valid_i  in  1  beat valid
- read_addr_i  in  BA_W  beat index in line (ignored when LINE2BE_W=0)
- read_rdata_i  in  BE_DATA_W  beat data
- busy_o  out  1  fill in progress (FILL or COMMIT)
- line_valid_o  out  1  assembled line available
- line_ready_i  in  1  consumer accepts line
- line_data_o  out  BE_DATA_W*NBEATS  assembled line; beat k at [k*BE_DATA_W +: BE_DATA_W]
- word_o  out  DATA_W  requested word = line_data_o[miss_word*DATA_W +: DATA_W]
- err_o  out  1  one-cycle pulse: replacement ended with incomplete line

Behaviour:
- Reset (synchronous, reset_i high at clk_i edge): state=IDLE; busy_o=0, line_valid_o=0, err_o=0, line_data_o=0, word_o=0, beat mask=0, replace_seen=0, captured miss word=0. Reset mid-fill or mid-COMMIT aborts with no line_valid_o or err_o.
- IDLE: on miss_valid_i, capture miss_word_i, clear mask and replace_seen, go to FILL. Beats arriving in IDLE are ignored.
- FILL:
  - read_valid_i high: line buffer beat[read_addr_i] <= read_rdata_i; mask[read_addr_i] <= 1. With LINE2BE_W=0, beat 0 is always written.
  - A repeated beat index (retry burst after slave error) overwrites the data; mask stays set.
  - replace_i high sets replace_seen.
  - When replace_seen=1 and replace_i=0: mask all ones -> COMMIT, with line_valid_o=1 registered on the next edge. Otherwise -> IDLE with err_o pulsed high for exactly one cycle and no line_valid_o.
  - read_valid_i in the same cycle as the replace_i low sample: the beat is still written before the completeness check.
- COMMIT:
  - line_valid_o=1; line_data_o and word_o held stable.
  - line_ready_i high -> IDLE next edge, line_valid_o=0 next cycle.
  - Beats and miss_valid_i are ignored.
  - line_ready_i may be tied high, giving a 1-cycle line_valid_o pulse.
- busy_o = (state != IDLE), registered with the state.
- Latency: last beat at cycle t. Read channel drops replace_i at t+2. line_valid_o is high at t+3.
- word_o selection uses the captured miss word, never live miss_word_i.

Test Plan:
- BE_DATA_W=64, DATA_W=32, WORD_OFFSET_W=3 (4 beats), miss_word=5. Beats 0..3 = 0x11..11_00..00 + k with replace_i held, then dropped -> line_valid_o at t+3; line_data_o beat k correct; word_o = upper half of beat 2.
- Same config; beat 2 sent twice with data 0xAAAA then 0xBBBB (retry) -> committed beat 2 = 0xBBBB; no err_o.
- Only beats 0,1,2 delivered, then replace_i falls -> err_o high exactly 1 cycle; line_valid_o stays 0; busy_o=0 the next cycle.
- line_ready_i held low for 5 cycles in COMMIT, with a new miss_valid_i and stray beats injected -> line_data_o unchanged, line_valid_o held; release ready -> IDLE, the new miss was not captured.
- LINE2BE_W=0 (BE_DATA_W=32, WORD_OFFSET_W=0): single beat 0xDEADBEEF -> line_data_o=word_o=0xDEADBEEF.
- reset_i asserted mid-FILL after 2 beats -> all outputs 0 next cycle; subsequent miss starts with an empty mask.
